// File: rtl/hex_display_sequencer_pkg.sv
// Shared definitions for the hex display sequencer: blank segment code,
// FSM state encoding and the digit index width helper.
package hex_display_sequencer_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // A single digit still needs a one-bit index register.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex_display_sequencer_hexadigit4.sv
// Combinational nibble to active-low seven-segment decoder (bit 6 = g, bit 0 = a).
module hexadigit4 (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Fixed glyph table for 0..F.
    always_comb begin
        seg = 7'h7F;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/hex_display_sequencer.sv
// Captures a word, scans its nibbles MSB-first through one shared decoder
// into a shadow bank, then commits the whole bank to the displays at once.
//
// state  | meaning
// IDLE   | ready for a new word; displays hold last committed value
// SCAN   | decoding nibble idx into shadow slot idx, counting down to 0
// COMMIT | copy shadow bank to hex_out in one edge and pulse done
module hex_display_sequencer
    import hex_display_sequencer_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [4*NUM_DIGITS-1:0] in_data,
    output logic                    in_ready,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic                    busy,
    output logic                    done
);

    localparam int IW = idx_width(NUM_DIGITS);

    state_t                    state;
    logic [IW-1:0]             idx;
    logic                      seen_nz;
    logic [4*NUM_DIGITS-1:0]   word;
    logic [7*NUM_DIGITS-1:0]   shadow;
    logic [3:0]                nib;
    logic [6:0]                seg;
    logic [6:0]                slot;

    assign nib      = word[int'(idx) * 4 +: 4];
    assign in_ready = (state == ST_IDLE) & rst_n;
    assign busy     = (state != ST_IDLE);

    hexadigit4 u_dec (
        .nib (nib),
        .seg (seg)
    );

    // Leading zeros are blanked until the first non-zero nibble; digit 0 always shows.
    always_comb begin
        slot = seg;
        if (BLANK_LEADING && !seen_nz && (nib == 4'h0) && (idx != '0))
            slot = SEG_BLANK;
    end

    // Sequencer FSM with registered display bank and done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            seen_nz <= 1'b0;
            word    <= '0;
            shadow  <= {NUM_DIGITS{SEG_BLANK}};
            hex_out <= {NUM_DIGITS{SEG_BLANK}};
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        word    <= in_data;
                        idx     <= IW'(NUM_DIGITS - 1);
                        seen_nz <= 1'b0;
                        state   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    shadow[int'(idx) * 7 +: 7] <= slot;
                    if (nib != 4'h0)
                        seen_nz <= 1'b1;
                    if (idx == '0)
                        state <= ST_COMMIT;
                    else
                        idx <= idx - 1'b1;
                end
                ST_COMMIT: begin
                    hex_out <= shadow;
                    done    <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Bench for hex_display_sequencer: two instances (leading-zero blanking on
// and off) share one stimulus stream; a queue scoreboard checks each commit.
module tb_hex_display_sequencer;

    localparam logic [27:0] ALL_BLANK = {7'h7F, 7'h7F, 7'h7F, 7'h7F};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        in_ready, busy, done;
    logic [27:0] hex_out;
    logic        in_ready0, busy0, done0;
    logic [27:0] hex_out0;

    always #5 clk = ~clk;

    hex_display_sequencer #(.NUM_DIGITS(4), .BLANK_LEADING(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .hex_out  (hex_out),
        .busy     (busy),
        .done     (done)
    );

    hex_display_sequencer #(.NUM_DIGITS(4), .BLANK_LEADING(1'b0)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready0),
        .hex_out  (hex_out0),
        .busy     (busy0),
        .done     (done0)
    );

    typedef struct {
        logic [27:0] e1;
        logic [27:0] e0;
        int          acc;
    } sb_t;

    typedef struct {
        logic [15:0] data;
        logic [27:0] e1;
        logic [27:0] e0;
    } vec_t;

    sb_t         q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        rst_q = 1'b0;
    logic [27:0] prev1, prev0;
    logic        prev_done = 1'b0;

    always @(posedge clk) begin
        cyc++;
        rst_q = rst_n;
    end

    // Scoreboard and single-cycle-update monitor.
    always @(negedge clk) begin
        sb_t e;
        if (done || done0) begin
            checks++;
            if (done !== done0) begin
                errors++;
                $display("FAIL done_match: blank=%b noblank=%b", done, done0);
            end
            checks++;
            if (prev_done) begin
                errors++;
                $display("FAIL done_width: done high for more than one cycle at cyc %0d", cyc);
            end
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with no word pending at cyc %0d", cyc);
            end else begin
                e = q.pop_front();
                checks += 3;
                if (hex_out !== e.e1) begin
                    errors++;
                    $display("FAIL commit_blank: got %h want %h", hex_out, e.e1);
                end
                if (hex_out0 !== e.e0) begin
                    errors++;
                    $display("FAIL commit_noblank: got %h want %h", hex_out0, e.e0);
                end
                if (cyc - e.acc != 6) begin
                    errors++;
                    $display("FAIL latency: got %0d want 6", cyc - e.acc);
                end
            end
        end
        if (rst_q && (hex_out !== prev1)) begin
            checks++;
            if (!done) begin
                errors++;
                $display("FAIL partial_update_blank: hex %h -> %h without done", prev1, hex_out);
            end
        end
        if (rst_q && (hex_out0 !== prev0)) begin
            checks++;
            if (!done0) begin
                errors++;
                $display("FAIL partial_update_noblank: hex %h -> %h without done", prev0, hex_out0);
            end
        end
        prev1     = hex_out;
        prev0     = hex_out0;
        prev_done = done | done0;
    end

    task automatic wait_accept(input logic [27:0] d1, input logic [27:0] d0, output int at);
        int n = 0;
        while (!(in_ready && in_ready0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        at = cyc;
        if (!(in_ready && in_ready0)) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b/%b want 1", in_ready, in_ready0);
        end else begin
            q.push_back('{d1, d0, cyc});
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d words never committed", q.size());
            q.delete();
        end
    endtask

    task automatic check28(input string name, input logic [27:0] got, input logic [27:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    initial begin
        vec_t vecs[10];
        int   t1, t2;

        vecs[0] = '{16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{16'h00A0, {7'h7F, 7'h7F, 7'h08, 7'h40}, {7'h40, 7'h40, 7'h08, 7'h40}};
        vecs[2] = '{16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[3] = '{16'h0001, {7'h7F, 7'h7F, 7'h7F, 7'h79}, {7'h40, 7'h40, 7'h40, 7'h79}};
        vecs[4] = '{16'h1000, {7'h79, 7'h40, 7'h40, 7'h40}, {7'h79, 7'h40, 7'h40, 7'h40}};
        vecs[5] = '{16'h0F05, {7'h7F, 7'h0E, 7'h40, 7'h12}, {7'h40, 7'h0E, 7'h40, 7'h12}};
        vecs[6] = '{16'h67DE, {7'h02, 7'h78, 7'h21, 7'h06}, {7'h02, 7'h78, 7'h21, 7'h06}};
        vecs[7] = '{16'h8B0C, {7'h00, 7'h03, 7'h40, 7'h46}, {7'h00, 7'h03, 7'h40, 7'h46}};
        vecs[8] = '{16'hFFFF, {7'h0E, 7'h0E, 7'h0E, 7'h0E}, {7'h0E, 7'h0E, 7'h0E, 7'h0E}};
        vecs[9] = '{16'h9ABC, {7'h10, 7'h08, 7'h03, 7'h46}, {7'h10, 7'h08, 7'h03, 7'h46}};

        // Reset, then idle.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check28("reset_hex_blank", hex_out, ALL_BLANK);
        check28("reset_hex_noblank", hex_out0, ALL_BLANK);
        check1("reset_ready", in_ready & in_ready0, 1'b1);
        check1("reset_done", done | done0, 1'b0);
        check1("reset_busy", busy | busy0, 1'b0);

        // Table-driven single words; in_data is scrambled right after accept.
        foreach (vecs[i]) begin
            in_valid = 1'b1;
            in_data  = vecs[i].data;
            wait_accept(vecs[i].e1, vecs[i].e0, t1);
            in_valid = 1'b0;
            in_data  = 16'($urandom);
            drain();
            check28("table_blank", hex_out, vecs[i].e1);
            check28("table_noblank", hex_out0, vecs[i].e0);
        end

        // Held in_valid: back-to-back accepts, in_data changes during SCAN ignored.
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        wait_accept(vecs[8].e1, vecs[8].e0, t1);
        check1("scan_busy", busy & busy0, 1'b1);
        check1("scan_not_ready", in_ready | in_ready0, 1'b0);
        in_data = 16'h1234;
        @(negedge clk);
        in_data = 16'h8B0C;
        wait_accept(vecs[7].e1, vecs[7].e0, t2);
        in_valid = 1'b0;
        checks++;
        if (t2 - t1 != 6) begin
            errors++;
            $display("FAIL accept_spacing: got %0d want 6", t2 - t1);
        end
        drain();
        check28("b2b_final_blank", hex_out, vecs[7].e1);

        // Reset mid-scan discards the word.
        in_valid = 1'b1;
        in_data  = 16'h1234;
        wait_accept(vecs[0].e1, vecs[0].e0, t1);
        in_valid = 1'b0;
        drain();
        in_valid = 1'b1;
        in_data  = 16'h5678;
        wait_accept(28'h0, 28'h0, t1);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        q.delete();
        check1("rst_ready_low", in_ready | in_ready0, 1'b0);
        check28("rst_hex_blank", hex_out, ALL_BLANK);
        check28("rst_hex_noblank", hex_out0, ALL_BLANK);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check28("rst_hold_blank", hex_out, ALL_BLANK);
        check1("rst_idle_busy", busy | busy0, 1'b0);

        in_valid = 1'b1;
        in_data  = 16'h9ABC;
        wait_accept(vecs[9].e1, vecs[9].e0, t1);
        in_valid = 1'b0;
        drain();
        check28("after_rst_blank", hex_out, vecs[9].e1);
        check28("after_rst_noblank", hex_out0, vecs[9].e0);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_display_sequencer.md
# hex_display_sequencer

Loads a 16-bit value (e.g. the LFSR state) into a bank of four active-low seven-segment displays through one shared `hexadigit4` decoder. The block captures a word through a valid/ready handshake and scans its nibbles MSB-first through the decoder. Results go into a shadow bank, which is committed to the display outputs in one cycle, so a display never shows a mix of old and new digits. It sits between the value source and the HEX pins.

## Interface
- `NUM_DIGITS`, 4: number of displays / nibbles, range 1..8.
- `BLANK_LEADING`, 1: 1 = blank leading zero digits (digit 0 always shown); 0 = show all digits.

- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  `in_data` is offered.
- `in_data`  in  4*NUM_DIGITS  value; nibble i drives display i (nibble 0 = LS = HEX0).
- `in_ready`  out  1  block can accept a word.
- `hex_out`  out  7*NUM_DIGITS  segments, active-low; digit i at bits [7i+6:7i], bit 6 = segment g, bit 0 = segment a.
- `busy`  out  1  a scan or commit is in progress.
- `done`  out  1  one-cycle pulse; asserted in the first cycle the new `hex_out` is visible.

## Operation
- FSM states: IDLE, SCAN, COMMIT.
- **IDLE**
  - `in_ready`=1, `busy`=0.
  - On `in_valid` & `in_ready`: register `in_data`; set `idx`=NUM_DIGITS-1; clear `seen_nz`; go to SCAN.
- **SCAN**
  - Each cycle, `nib` = captured[4*idx+3:4*idx] feeds the shared decoder.
  - The shadow slot `idx` takes 7'h7F (blank) when BLANK_LEADING=1, `seen_nz`=0, `nib`=0 and `idx`!=0. Otherwise it takes the decoder output.
  - `seen_nz` is set when `nib`!=0.
  - If `idx`==0, go to COMMIT; otherwise decrement `idx`.
- **COMMIT**
  - `hex_out` <= shadow (all digits in the same edge); `done` <= 1; go to IDLE.
- Decoder map (active-low, g..a):
  - 0=40, 1=79, 2=24, 3=30
  - 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, B=03
  - C=46, D=21, E=06, F=0E
- `in_valid` while `in_ready`=0 is ignored. `in_data` is not sampled, and the source must hold its word until it sees the handshake.
- `hex_out` holds its last committed value indefinitely between updates.

## Timing
- Reset (`rst_n`=0 at a rising edge, in any state, including mid-SCAN/COMMIT):
  - state=IDLE, `hex_out`=all 7'h7F, shadow=all 7'h7F, `idx`=0, `seen_nz`=0, `done`=0.
  - `in_ready` = (state==IDLE) & `rst_n`, so it reads 0 while `rst_n` is low.
  - A word that was mid-scan is discarded and never committed.
- `in_ready` and `busy` are decoded from state; `done` and `hex_out` are registered.
- Latency: handshake at edge E0 → SCAN in cycles E0..E0+NUM_DIGITS-1 → COMMIT at E0+NUM_DIGITS. New `hex_out` and `done`=1 appear after edge E0+NUM_DIGITS+1.
- Throughput: `in_ready` is high again in the `done` cycle. Back-to-back words are accepted every NUM_DIGITS+2 cycles.
- NUM_DIGITS=1: SCAN lasts one cycle; digit 0 is never blanked.

## Structure
- Shared package holds:
  - `SEG_BLANK` = 7'h7F;
  - the FSM state enum (IDLE/SCAN/COMMIT);
  - `idx` width = $clog2(NUM_DIGITS) (minimum 1).
- One sub-module: the existing combinational `hexadigit4` (4-bit in, 7-bit active-low out), instantiated exactly once and time-shared across digits.
- No other hierarchy. Shadow bank and `hex_out` are flat 7*NUM_DIGITS registers.

## Test plan
- Reset, then idle 5 cycles → `hex_out`=7F7F7F7F (per digit), `in_ready`=1, `done`=0.
- BLANK_LEADING=1, send 0x1234 → after 6 cycles `done` pulses once; `hex_out` digits 3..0 = 79,24,30,19.
- Send 0x00A0 → digits 3..0 = 7F,7F,08,40. Send 0x0000 → 7F,7F,7F,40. With BLANK_LEADING=0, 0x0000 → 40,40,40,40.
- Hold `in_valid` high with 0xFFFF, then 0x8B0C on consecutive accepts:
  - accepts exactly 6 cycles apart;
  - `in_data` changes during SCAN are ignored;
  - final digits 3..0 = 00,03,40,46 (8,B,0,C; zero not leading).
- Accept 0x5678 after 0x1234 is committed; pull `rst_n` low for one edge mid-SCAN → `hex_out`=all 7F, no `done`. A fresh 0x9ABC then yields 10,08,03,46.
- Check that `hex_out` changes in exactly one cycle per update, with no partial-update cycle, across all of the above.
